// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, per-channel counter debounce
// FSM, registered debounced level and a single-cycle press pulse.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_btn        raw asynchronous buttons, 1 = pressed
//   o_btn_level  debounced level per channel
//   o_btn_pulse  one-cycle pulse per accepted press (never on release)
module btn_debounce #(
    parameter int NB_BTN          = 4,
    parameter int NB_CNT          = 20,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NB_BTN-1:0] i_btn,
    output logic [NB_BTN-1:0] o_btn_level,
    output logic [NB_BTN-1:0] o_btn_pulse
);

    localparam logic [1:0] IDLE_LOW  = 2'd0;
    localparam logic [1:0] WAIT_HIGH = 2'd1;
    localparam logic [1:0] IDLE_HIGH = 2'd2;
    localparam logic [1:0] WAIT_LOW  = 2'd3;

    // Last count value before a change is accepted; the counter is
    // cleared on acceptance so it never has to hold DEBOUNCE_CYCLES.
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);
    localparam logic [NB_CNT-1:0] CNT_ONE  = NB_CNT'(1);

    logic [NB_BTN-1:0] sync1_q;
    logic [NB_BTN-1:0] sync2_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= i_btn;
            sync2_q <= sync1_q;
        end
    end

    genvar g;
    for (g = 0; g < NB_BTN; g++) begin : g_ch
        logic              s;
        logic [1:0]        state_q;
        logic [1:0]        state_d;
        logic [NB_CNT-1:0] cnt_q;
        logic [NB_CNT-1:0] cnt_d;
        logic              level_q;
        logic              level_d;
        logic              pulse_q;
        logic              pulse_d;

        assign s = sync2_q[g];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            level_d = level_q;
            pulse_d = 1'b0;
            case (state_q)
                IDLE_LOW: begin
                    if (s) begin
                        state_d = WAIT_HIGH;
                        cnt_d   = '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!s) begin
                        // bounce back low: restart from scratch
                        state_d = IDLE_LOW;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE_HIGH;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (!s) begin
                        state_d = WAIT_LOW;
                        cnt_d   = '0;
                    end
                end
                WAIT_LOW: begin
                    if (s) begin
                        state_d = IDLE_HIGH;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        // release accepted; no pulse on release
                        state_d = IDLE_LOW;
                        cnt_d   = '0;
                        level_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end
            endcase
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                state_q <= IDLE_LOW;
                cnt_q   <= '0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                pulse_q <= pulse_d;
            end
        end

        assign o_btn_level[g] = level_q;
        assign o_btn_pulse[g] = pulse_q;
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios plus randomized bouncing,
// every cycle compared against a run-length reference model.
module tb_btn_debounce;

    localparam int NB = 4;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn;
    logic [NB-1:0] lvl;
    logic [NB-1:0] pul;

    btn_debounce #(
        .NB_BTN(NB),
        .NB_CNT(3),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_btn(btn),
        .o_btn_level(lvl),
        .o_btn_pulse(pul)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference: input delayed two edges; a channel's level flips once
    // the delayed input has disagreed with it on D+1 consecutive edges.
    logic [NB-1:0] h1, h2, m_lvl, m_pul;
    int            run [NB];

    task automatic mreset();
        h1 = '0;
        h2 = '0;
        m_lvl = '0;
        m_pul = '0;
        for (int i = 0; i < NB; i++) run[i] = 0;
    endtask

    task automatic mupdate();
        logic [NB-1:0] s;
        s = h2;
        h2 = h1;
        h1 = btn;
        m_pul = '0;
        for (int i = 0; i < NB; i++) begin
            if (s[i] != m_lvl[i]) begin
                run[i]++;
                if (run[i] == D + 1) begin
                    m_lvl[i] = s[i];
                    m_pul[i] = s[i];
                    run[i] = 0;
                end
            end else begin
                run[i] = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [NB-1:0] got,
                       input logic [NB-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Called at a falling edge: drive, clock, model, compare.
    task automatic step(input logic [NB-1:0] b);
        btn = b;
        @(posedge clk);
        mupdate();
        @(negedge clk);
        chk("level", lvl, m_lvl);
        chk("pulse", pul, m_pul);
    endtask

    task automatic hold(input logic [NB-1:0] b, input int n, input int ch,
                        output int fp, output int np, output int fl,
                        output logic [NB-1:0] fpv);
        logic l0;
        l0  = lvl[ch];
        fp  = -1;
        np  = 0;
        fl  = -1;
        fpv = '0;
        for (int e = 0; e < n; e++) begin
            step(b);
            if (pul[ch]) begin
                np++;
                if (fp < 0) begin
                    fp  = e;
                    fpv = pul;
                end
            end
            if (fl < 0 && lvl[ch] != l0) fl = e;
        end
    endtask

    initial begin
        int fp, np, fl, acc;
        logic [NB-1:0] fpv;
        logic [NB-1:0] cur;
        int left [NB];

        rst = 1'b1;
        btn = '0;
        mreset();
        @(negedge clk);
        chk("rst_level", lvl, '0);
        chk("rst_pulse", pul, '0);
        rst = 1'b0;
        hold('0, 5, 0, fp, np, fl, fpv);

        // clean press on bit 1
        hold(4'b0010, 20, 1, fp, np, fl, fpv);
        chk_i("press_pulse_edge", fp, D + 2);
        chk_i("press_level_edge", fl, D + 2);
        chk_i("press_pulse_cnt", np, 1);
        chk("press_vec", fpv, 4'b0010);
        chk("press_hold_lvl", lvl, 4'b0010);
        hold('0, 10, 1, fp, np, fl, fpv);
        chk_i("rel1_level_edge", fl, D + 2);

        // bounce on bit 0
        acc = 0;
        for (int k = 0; k < 2; k++) begin
            hold(4'b0001, 2, 0, fp, np, fl, fpv);
            acc += np;
            hold(4'b0000, 2, 0, fp, np, fl, fpv);
            acc += np;
        end
        chk_i("bounce_no_pulse", acc, 0);
        hold(4'b0001, 20, 0, fp, np, fl, fpv);
        chk_i("bounce_pulse_edge", fp, D + 2);
        chk_i("bounce_pulse_cnt", np, 1);

        // short low glitch while held, then release
        hold(4'b0000, 3, 0, fp, np, fl, fpv);
        chk_i("glitch_lvl_a", fl, -1);
        hold(4'b0001, 10, 0, fp, np, fl, fpv);
        chk_i("glitch_lvl_b", fl, -1);
        hold(4'b0000, 12, 0, fp, np, fl, fpv);
        chk_i("release_edge", fl, D + 2);
        chk_i("release_no_pulse", np, 0);

        // simultaneous press
        hold(4'b0101, 12, 0, fp, np, fl, fpv);
        chk_i("simul_edge", fp, D + 2);
        chk("simul_vec", fpv, 4'b0101);
        chk_i("simul_cnt", np, 1);
        hold('0, 10, 0, fp, np, fl, fpv);

        // async reset while bit 3 is mid-count
        hold(4'b0010, 10, 1, fp, np, fl, fpv);
        hold(4'b1010, 4, 3, fp, np, fl, fpv);
        chk("pre_rst_level", lvl, 4'b0010);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_level", lvl, '0);
        chk("async_rst_pulse", pul, '0);
        mreset();
        #1 rst = 1'b0;
        hold(4'b1010, 20, 3, fp, np, fl, fpv);
        chk_i("post_rst_edge", fp, D + 2);
        chk("post_rst_vec", fpv, 4'b1010);
        chk_i("post_rst_cnt", np, 1);
        hold('0, 10, 3, fp, np, fl, fpv);

        // long hold
        hold(4'b0100, 100, 2, fp, np, fl, fpv);
        chk_i("long_hold_cnt", np, 1);
        hold('0, 10, 2, fp, np, fl, fpv);

        // randomized bouncing on all channels
        cur = '0;
        for (int i = 0; i < NB; i++) left[i] = 0;
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < NB; i++) begin
                if (left[i] == 0) begin
                    cur[i] = 1'($urandom_range(0, 1));
                    left[i] = (($urandom & 3) == 0) ?
                              int'($urandom_range(6, 20)) :
                              int'($urandom_range(1, 6));
                end
                left[i]--;
            end
            step(cur);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Conditions the raw board push-buttons before they reach the ALU operand/opcode latch stage (A, B, opcode load, reset request).
- Per button: a 2-flop synchronizer, a counter-based debounce FSM, a debounced level output and a single-cycle press pulse.
- The latch stage consumes the pulses, so one physical press loads exactly one value, even with contact bounce or a long hold.
- Channels are independent; one counter per channel.

Parameters:
- NB_BTN, 4, number of button channels (bit 0 = R, 1 = C, 2 = L, 3 = U).
- NB_CNT, 20, debounce counter width.
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized cycles required to accept a change (10 ms at 100 MHz). Legal range 2 to 2^NB_CNT.

Ports:
- i_clk  input  1  system clock, all flops on the rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_btn  input  NB_BTN  raw asynchronous button inputs, 1 = pressed.
- o_btn_level  output  NB_BTN  debounced button level.
- o_btn_pulse  output  NB_BTN  one-cycle pulse per accepted press.

Behaviour:
- Reset (async assert, any time, including mid-count):
  - sync flops = 0, counters = 0, every FSM in IDLE_LOW.
  - o_btn_level = 0, o_btn_pulse = 0.
  - Deassertion is used directly; no internal reset synchronizer is required.
- Synchronizer: s[i] = i_btn[i] delayed by 2 flops. The FSM sees only s[i].
- Per-channel FSM, states IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW:
  - IDLE_LOW: if s=1, go to WAIT_HIGH and set cnt to 0. Otherwise hold.
  - WAIT_HIGH, s=0 (bounce): go to IDLE_LOW, cnt = 0, no output change.
  - WAIT_HIGH, s=1, cnt == DEBOUNCE_CYCLES-1: go to IDLE_HIGH, set level = 1, set pulse = 1 for the next cycle only.
  - WAIT_HIGH, s=1, otherwise: cnt = cnt+1.
  - IDLE_HIGH: if s=0, go to WAIT_LOW and set cnt to 0. Otherwise hold; the pulse is already 0.
  - WAIT_LOW: mirror of WAIT_HIGH with s=0 as the target. On acceptance go to IDLE_LOW and set level = 0. No pulse on release.
- Outputs are registered. o_btn_pulse is high for exactly 1 cycle per accepted press, regardless of hold duration.
- Latency: let edge 0 be the first rising edge that samples i_btn=1, with the input held stable afterwards. o_btn_level and o_btn_pulse go high after edge DEBOUNCE_CYCLES+2. Release latency on o_btn_level is the same.
- Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no output change and restarts the count on the next change.
- The counter never wraps: it is compared and cleared before reaching DEBOUNCE_CYCLES.
- Simultaneous presses on several channels are processed independently. Coincident pulses are permitted; the downstream decode rejects non-one-hot vectors.
- A button held through reset deassertion is treated as a fresh press: full debounce, then one pulse.

Test Plan (DEBOUNCE_CYCLES=4, NB_CNT=3 for simulation):
- Clean press: i_btn[1] rises and is held 20 cycles -> o_btn_level[1]=1 and o_btn_pulse[1]=1 after edge 6. Pulse is 0 at edge 7 onward while level stays 1. Other bits stay 0.
- Bounce: i_btn[0] toggles 1,0,1,0 with 2-cycle widths, then holds 1 -> no pulse during bouncing. Exactly one pulse, DEBOUNCE_CYCLES+2 edges after the final rise.
- Release: after an accepted press, drop i_btn[0] -> o_btn_level[0]=0 after edge 6 relative to the fall. No pulse. A 3-cycle low glitch while held causes no level change.
- Simultaneous: i_btn=4'b0101 from edge 0 -> o_btn_pulse=4'b0101 in one cycle, after edge 6.
- Async reset mid-count: assert i_rst between edges while in WAIT_HIGH -> o_btn_level/o_btn_pulse drop to 0 immediately with no clock edge. After deassertion with the button still held, one pulse follows a full DEBOUNCE_CYCLES+2 delay.
- Long hold: i_btn[2] held 100 cycles -> exactly one o_btn_pulse[2] cycle observed.
